// File: rtl/sram2_pkg.sv
// Shared constants and the per-byte parity helper for the second SRAM region.
package sram2_pkg;

  localparam logic [31:0] SRAM2_BASE = 32'h1000_0000;
  localparam int          DATA_W     = 32;
  localparam int          PAR_W      = 4;
  localparam int          WORD_W     = DATA_W + PAR_W;

  // Even parity: the bit equals the XOR of its byte, so a byte with an even count of ones maps to 0.
  function automatic logic [PAR_W-1:0] byte_parity(input logic [DATA_W-1:0] data);
    logic [PAR_W-1:0] par;
    par = '0;
    for (int i = 0; i < PAR_W; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/sram2_parity_check.sv
// Splits a stored 36-bit word into its data and a parity-mismatch indication.
module sram2_parity_check
  import sram2_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [DATA_W-1:0] o_data,
  output logic              o_error
);

  logic [PAR_W-1:0] w_expected_par;

  assign w_expected_par = byte_parity(i_word[DATA_W-1:0]);
  assign o_data         = i_word[DATA_W-1:0];
  assign o_error        = |(w_expected_par ^ i_word[WORD_W-1:DATA_W]);

endmodule

// File: rtl/sram2_mem.sv
// Word SRAM with stored per-byte parity, mapped at a fixed window of the system address space.
module sram2_mem
  import sram2_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAM2_BASE,
  parameter int          DEPTH     = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write_enable,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_error_flag
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] WINDOW_LEN = 32'(4 * DEPTH);

  logic [31:0]       w_offset;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_error;

  // Unsigned wrap makes addresses below the base look huge, so one compare covers both bounds.
  assign w_offset = address - BASE_ADDR;
  assign w_hit    = (w_offset < WINDOW_LEN);
  assign w_idx    = w_offset[IDX_W+1:2];

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_word;
  logic              r_rd_hit;

  always_ff @(posedge clock) begin
    if (reset_n && w_hit) begin
      if (write_enable) begin
        r_mem[w_idx] <= data_in;
      end else begin
        r_rd_word <= r_mem[w_idx];
      end
    end
  end

  // Write cycles leave both the captured word and the hit qualifier alone, so outputs hold.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_hit <= 1'b0;
    end else if (!write_enable) begin
      r_rd_hit <= w_hit;
    end
  end

  sram2_parity_check u_parity_check (
    .i_word  (r_rd_word),
    .o_data  (w_rd_data),
    .o_error (w_rd_error)
  );

  assign data_out          = r_rd_hit ? w_rd_data : '0;
  assign parity_error_flag = r_rd_hit & w_rd_error;

endmodule

// File: tb/tb_sram2_mem.sv
// Table-driven bench for sram2_mem with a scoreboard queue of expected read-port values.
module tb_sram2_mem;

  logic        clock;
  logic        reset_n;
  logic        write_enable;
  logic [31:0] address;
  logic [35:0] data_in;
  logic [31:0] data_out;
  logic        parity_error_flag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        flag;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [35:0] din;
    logic [31:0] exp_d;
    logic        exp_f;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  sram2_mem #(.BASE_ADDR(32'h1000_0000), .DEPTH(1024)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .write_enable      (write_enable),
    .address           (address),
    .data_in           (data_in),
    .data_out          (data_out),
    .parity_error_flag (parity_error_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one cycle, queue the expected outputs, then pop and compare just after the edge.
  task automatic cycle(input logic rst_n, input logic we, input logic [31:0] a,
                       input logic [35:0] d, input logic [31:0] ed, input logic ef,
                       input string nm);
    exp_t e;
    reset_n      = rst_n;
    write_enable = we;
    address      = a;
    data_in      = d;
    exp_q.push_back('{data: ed, flag: ef, name: nm});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty, expected an entry", nm);
      return;
    end
    e = exp_q.pop_front();
    $display("txn %-18s rst_n=%0b we=%0b addr=%h din=%h -> data_out=%h flag=%0b (exp %h/%0b)",
             e.name, rst_n, we, a, d, data_out, parity_error_flag, e.data, e.flag);
    checks++;
    if (data_out !== e.data) begin
      errors++;
      $display("FAIL %s data_out: got %h, expected %h", e.name, data_out, e.data);
    end
    checks++;
    if (parity_error_flag !== e.flag) begin
      errors++;
      $display("FAIL %s flag: got %b, expected %b", e.name, parity_error_flag, e.flag);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    data_in      = '0;

    // Reset held for two cycles.
    cycle(1'b0, 1'b0, 32'h1000_0000, 36'h0, 32'h0, 1'b0, "reset0");
    cycle(1'b0, 1'b0, 32'h1000_0000, 36'h0, 32'h0, 1'b0, "reset1");

    vecs.push_back('{1'b1, 32'h1000_0000, {4'b0000, 32'hA5A5A5A5}, 32'h0,        1'b0, "wr0_good"});
    vecs.push_back('{1'b0, 32'h1000_0000, 36'h0,                    32'hA5A5A5A5, 1'b0, "rd0_good"});
    vecs.push_back('{1'b1, 32'h1000_0000, {4'b1111, 32'hA5A5A5A5}, 32'hA5A5A5A5, 1'b0, "wr0_bad_hold"});
    vecs.push_back('{1'b0, 32'h1000_0000, 36'h0,                    32'hA5A5A5A5, 1'b1, "rd0_bad"});
    vecs.push_back('{1'b1, 32'h1000_0004, {4'b0000, 32'h5A5A5A5A}, 32'hA5A5A5A5, 1'b1, "wr1_good_hold"});
    vecs.push_back('{1'b0, 32'h1000_0004, 36'h0,                    32'h5A5A5A5A, 1'b0, "rd1_good"});
    vecs.push_back('{1'b1, 32'h1000_0004, {4'b1010, 32'h5A5A5A5A}, 32'h5A5A5A5A, 1'b0, "wr1_bad_hold"});
    vecs.push_back('{1'b0, 32'h1000_0004, 36'h0,                    32'h5A5A5A5A, 1'b1, "rd1_bad"});
    vecs.push_back('{1'b1, 32'h0FFF_FFFC, {4'b0000, 32'h12345678}, 32'h5A5A5A5A, 1'b1, "wr_below_hold"});
    vecs.push_back('{1'b0, 32'h0FFF_FFFC, 36'h0,                    32'h0,        1'b0, "rd_below_miss"});
    vecs.push_back('{1'b0, 32'h1000_0000, 36'h0,                    32'hA5A5A5A5, 1'b1, "rd0_again"});
    vecs.push_back('{1'b1, 32'h1000_0FFC, {4'b0001, 32'h00000001}, 32'hA5A5A5A5, 1'b1, "wr_last_hold"});
    vecs.push_back('{1'b0, 32'h1000_0FFC, 36'h0,                    32'h00000001, 1'b0, "rd_last"});
    vecs.push_back('{1'b0, 32'h1000_1000, 36'h0,                    32'h0,        1'b0, "rd_above_miss"});
    vecs.push_back('{1'b1, 32'h1000_1000, {4'b0000, 32'hDEADBEEF}, 32'h0,        1'b0, "wr_above_hold"});
    vecs.push_back('{1'b0, 32'h1000_0003, 36'h0,                    32'hA5A5A5A5, 1'b1, "rd0_lowbits"});
    vecs.push_back('{1'b0, 32'h1000_0004, 36'h0,                    32'h5A5A5A5A, 1'b1, "b2b_rd1"});
    vecs.push_back('{1'b0, 32'h1000_0FFC, 36'h0,                    32'h00000001, 1'b0, "b2b_rd_last"});
    vecs.push_back('{1'b0, 32'h1000_0000, 36'h0,                    32'hA5A5A5A5, 1'b1, "b2b_rd0"});

    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp_d, vecs[i].exp_f, vecs[i].name);
    end

    // Reset dominates a simultaneous write: outputs clear and word 0 keeps its contents.
    cycle(1'b0, 1'b1, 32'h1000_0000, {4'b0000, 32'h11111111}, 32'h0, 1'b0, "rst_with_write");
    cycle(1'b1, 1'b0, 32'h1000_0000, 36'h0, 32'hA5A5A5A5, 1'b1, "rd0_after_rst");

    // Write then immediate read of the same word returns the new data.
    cycle(1'b1, 1'b1, 32'h1000_0800, {4'b0110, 32'h00FF_FF00}, 32'hA5A5A5A5, 1'b1, "wr_mid_hold");
    cycle(1'b1, 1'b0, 32'h1000_0800, 36'h0, 32'h00FF_FF00, 1'b1, "rd_mid_bad");
    cycle(1'b1, 1'b1, 32'h1000_0800, {4'b0000, 32'h00FF_FF00}, 32'h00FF_FF00, 1'b1, "wr_mid_fix_hold");
    cycle(1'b1, 1'b0, 32'h1000_0800, 36'h0, 32'h00FF_FF00, 1'b0, "rd_mid_good");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
